// File: rtl/regfile_sb_if.sv
// Bus bundle for regfile_sb: read ports, writeback port, issue port and ready.
// The master side (decode/writeback) drives addresses and data; the slave is the register file.
interface regfile_sb_if #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 5,
  parameter int RD_PORTS = 2
);
  logic [RD_PORTS*DEPTH-1:0] rd_addr_i;
  logic [RD_PORTS*WIDTH-1:0] rd_data_o;
  logic [RD_PORTS-1:0]       rd_pend_o;
  logic                      wr_en_i;
  logic [DEPTH-1:0]          wr_addr_i;
  logic [WIDTH-1:0]          wr_data_i;
  logic                      iss_en_i;
  logic [DEPTH-1:0]          iss_addr_i;
  logic                      ready_o;

  modport master (
    output rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, iss_en_i, iss_addr_i,
    input  rd_data_o, rd_pend_o, ready_o
  );

  modport slave (
    input  rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, iss_en_i, iss_addr_i,
    output rd_data_o, rd_pend_o, ready_o
  );
endinterface

// File: rtl/regfile_sb.sv
// Multi-port integer register file with pending-writeback scoreboard and a
// post-reset clear sequence that zeroes every entry before accepting traffic.
//
// state | meaning
// CLEAR | zeroing mem[cnt] one entry per edge; reads return 0, writes/issues ignored
// RUN   | normal operation: writeback, issue, combinational reads with optional bypass
module regfile_sb #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 5,
  parameter int RD_PORTS = 2,
  parameter int BYPASS   = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  regfile_sb_if.slave  bus
);

  localparam int NREG = 1 << DEPTH;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [DEPTH-1:0]  cnt_q, cnt_d;
  logic [NREG-1:0]   pend_q, pend_d;
  logic [WIDTH-1:0]  mem_q [NREG];

  logic              mem_we;
  logic [DEPTH-1:0]  mem_waddr;
  logic [WIDTH-1:0]  mem_wdata;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  // Storage carries no reset; the CLEAR sequence is what initialises it.
  always_ff @(posedge clk_i) begin
    if (!rst_i && mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    unique case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        cnt_d     = cnt_q + DEPTH'(1);
        if (cnt_q == '1) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.wr_en_i && (bus.wr_addr_i != '0)) begin
          mem_we    = 1'b1;
          mem_waddr = bus.wr_addr_i;
          mem_wdata = bus.wr_data_i;
        end
        // Issue is applied after writeback so a same-address collision stays pending.
        if (bus.wr_en_i) begin
          pend_d[bus.wr_addr_i] = 1'b0;
        end
        if (bus.iss_en_i) begin
          pend_d[bus.iss_addr_i] = 1'b1;
        end
        pend_d[0] = 1'b0;
      end
      default: state_d = CLEAR;
    endcase
  end

  always_comb begin
    bus.rd_data_o = '0;
    bus.rd_pend_o = '0;
    if (state_q == RUN) begin
      for (int k = 0; k < RD_PORTS; k++) begin
        if (bus.rd_addr_i[k*DEPTH +: DEPTH] != '0) begin
          if ((BYPASS != 0) && bus.wr_en_i &&
              (bus.wr_addr_i == bus.rd_addr_i[k*DEPTH +: DEPTH])) begin
            bus.rd_data_o[k*WIDTH +: WIDTH] = bus.wr_data_i;
          end else begin
            bus.rd_data_o[k*WIDTH +: WIDTH] = mem_q[bus.rd_addr_i[k*DEPTH +: DEPTH]];
            bus.rd_pend_o[k]                = pend_q[bus.rd_addr_i[k*DEPTH +: DEPTH]];
          end
        end
      end
    end
  end

  assign bus.ready_o = (state_q == RUN);

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: a reference model predicts every cycle's read
// outputs into a queue; a negedge monitor pops and compares against the DUT.
module tb_regfile_sb;
  localparam int W   = 64;
  localparam int D   = 5;
  localparam int RP  = 2;
  localparam int BYP = 1;
  localparam int NR  = 1 << D;

  logic clk = 1'b0;
  logic rst = 1'b1;

  regfile_sb_if #(.WIDTH(W), .DEPTH(D), .RD_PORTS(RP)) bus ();

  regfile_sb #(.WIDTH(W), .DEPTH(D), .RD_PORTS(RP), .BYPASS(BYP)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [RP*W-1:0] d;
    logic [RP-1:0]   p;
    logic            r;
  } exp_t;

  exp_t        q[$];
  logic [W-1:0] m_mem [NR];
  bit          m_pend [NR];
  int          m_clear_left = NR;
  int          n_tests = 0;
  int          n_fail  = 0;
  bit          chk_en  = 0;

  function automatic logic [W-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // One clock cycle: apply inputs, predict outputs, advance the model across the edge.
  task automatic cyc(input bit r, input bit we, input int wa, input logic [W-1:0] wd,
                     input bit ie, input int ia, input int a0, input int a1);
    exp_t e;
    int   ra[RP];
    ra[0] = a0;
    ra[1] = a1;
    rst            = r;
    bus.wr_en_i    = we;
    bus.wr_addr_i  = D'(wa);
    bus.wr_data_i  = wd;
    bus.iss_en_i   = ie;
    bus.iss_addr_i = D'(ia);
    for (int k = 0; k < RP; k++) bus.rd_addr_i[k*D +: D] = D'(ra[k]);

    e.r = (m_clear_left == 0);
    e.d = '0;
    e.p = '0;
    for (int k = 0; k < RP; k++) begin
      if (e.r && ra[k] != 0) begin
        if (BYP != 0 && we && wa == ra[k]) begin
          e.d[k*W +: W] = wd;
        end else begin
          e.d[k*W +: W] = m_mem[ra[k]];
          e.p[k]        = m_pend[ra[k]];
        end
      end
    end
    if (chk_en) q.push_back(e);

    @(posedge clk);
    if (r) begin
      m_clear_left = NR;
      for (int i = 0; i < NR; i++) m_pend[i] = 0;
    end else if (m_clear_left > 0) begin
      m_clear_left--;
      if (m_clear_left == 0) for (int i = 0; i < NR; i++) m_mem[i] = '0;
    end else begin
      if (we && wa != 0) m_mem[wa] = wd;
      if (we) m_pend[wa] = 0;
      if (ie && ia != 0) m_pend[ia] = 1;
    end
    #1;
  endtask

  task automatic rand_cyc(input bit r, input int amax);
    int wa, ia, a0, a1;
    wa = $urandom_range(0, amax);
    ia = $urandom_range(0, amax);
    a0 = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, amax);
    a1 = ($urandom_range(0, 3) == 0) ? ia : $urandom_range(0, amax);
    cyc(r, 1'($urandom_range(0, 1)), wa, rnd64(), 1'($urandom_range(0, 2) == 0), ia, a0, a1);
  endtask

  task automatic read_all();
    for (int i = 0; i < NR; i += 2) cyc(0, 0, 0, '0, 0, 0, i, i + 1);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_tests++;
      if (bus.ready_o !== e.r) begin
        n_fail++;
        $display("FAIL ready_o at %0t: got %b expected %b", $time, bus.ready_o, e.r);
      end
      for (int k = 0; k < RP; k++) begin
        n_tests++;
        if (bus.rd_data_o[k*W +: W] !== e.d[k*W +: W]) begin
          n_fail++;
          $display("FAIL rd_data port%0d addr %0d at %0t: got %h expected %h", k,
                   bus.rd_addr_i[k*D +: D], $time, bus.rd_data_o[k*W +: W], e.d[k*W +: W]);
        end
        n_tests++;
        if (bus.rd_pend_o[k] !== e.p[k]) begin
          n_fail++;
          $display("FAIL rd_pend port%0d addr %0d at %0t: got %b expected %b", k,
                   bus.rd_addr_i[k*D +: D], $time, bus.rd_pend_o[k], e.p[k]);
        end
      end
    end
  end

  initial begin
    bus.rd_addr_i  = '0;
    bus.wr_en_i    = 1'b0;
    bus.wr_addr_i  = '0;
    bus.wr_data_i  = '0;
    bus.iss_en_i   = 1'b0;
    bus.iss_addr_i = '0;
    @(posedge clk);
    #1;
    cyc(1, 0, 0, '0, 0, 0, 0, 0);
    chk_en = 1;

    // Clear sequence after the initial reset, with traffic that must be ignored.
    for (int i = 0; i < NR + 4; i++) rand_cyc(0, NR - 1);

    cyc(0, 1, 7, 64'hDEAD_BEEF, 0, 0, 0, 0);
    cyc(0, 0, 0, '0, 0, 0, 7, 7);
    cyc(0, 1, 5, 64'h1234, 0, 0, 5, 7);
    cyc(0, 0, 0, '0, 0, 0, 5, 0);
    cyc(0, 1, 0, 64'hFFFF, 1, 0, 0, 0);
    cyc(0, 0, 0, '0, 0, 0, 0, 0);
    cyc(0, 0, 0, '0, 1, 3, 0, 0);
    cyc(0, 0, 0, '0, 0, 0, 3, 3);
    cyc(0, 1, 3, 64'h55, 1, 3, 3, 0);
    cyc(0, 0, 0, '0, 0, 0, 3, 3);
    cyc(0, 1, 3, 64'h55, 0, 0, 0, 0);
    cyc(0, 0, 0, '0, 0, 0, 3, 3);

    for (int i = 0; i < 300; i++) rand_cyc(0, 7);
    for (int i = 0; i < 200; i++) rand_cyc(0, NR - 1);
    read_all();

    // Reset over a populated file, writes attempted throughout the clear.
    rand_cyc(1, NR - 1);
    for (int i = 0; i < NR + 2; i++) rand_cyc(0, NR - 1);
    read_all();

    for (int i = 0; i < 100; i++) rand_cyc(0, 7);
    rand_cyc(1, 7);
    for (int i = 0; i < 10; i++) rand_cyc(0, NR - 1);
    rand_cyc(1, NR - 1);
    for (int i = 0; i < NR + 2; i++) rand_cyc(0, NR - 1);
    read_all();

    for (int i = 0; i < 200; i++) rand_cyc(0, 7);
    read_all();

    @(negedge clk);
    #1;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard drain: got %0d entries left expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
